// File: rtl/cordic_out_stage_pkg.sv
// ---------------------------------------------------------------------------
// cordic_out_stage_pkg
// Shared CORDIC types and constants.
//   CORDIC_W            - width of each signed result component
//   CORDIC_INV_GAIN_Q15 - 1/K for 12 micro-rotations, unsigned Q0.15
//   cordic_data         - packed {x, y, z} result beat
// ---------------------------------------------------------------------------
package cordic_out_stage_pkg;

    localparam int CORDIC_W = 16;

    // 0.607253 * 2^15, rounded
    localparam int unsigned CORDIC_INV_GAIN_Q15 = 19898;

    typedef struct packed {
        logic signed [CORDIC_W-1:0] x;
        logic signed [CORDIC_W-1:0] y;
        logic signed [CORDIC_W-1:0] z;
    } cordic_data;

endpackage

// File: rtl/cordic_out_fifo.sv
// ---------------------------------------------------------------------------
// cordic_out_fifo
// First-word-fall-through FIFO for compensated CORDIC results. The writer
// cannot be stalled, so a push into a full FIFO without a simultaneous pop is
// dropped and a sticky overflow flag is raised.
//   clk, srst   - clock, synchronous active-high reset
//   push        - write request (one beat per cycle)
//   push_data   - beat to write
//   head_valid  - head entry present (registered)
//   head_ready  - consumer takes the head this cycle
//   head_data   - head entry (registered, stable while not popped)
//   level       - occupancy, 0..DEPTH (registered)
//   overflow    - sticky dropped-beat flag
// ---------------------------------------------------------------------------
module cordic_out_fifo
    import cordic_out_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  cordic_data               push_data,
    output logic                     head_valid,
    input  logic                     head_ready,
    output cordic_data               head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    cordic_data             mem [DEPTH];
    logic [PTR_W-1:0]       rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [LEVEL_W-1:0]     level_reg, level_after_pop, level_next;
    logic                   valid_reg;
    logic                   overflow_reg;
    cordic_data             head_reg, head_next;

    logic pop;
    logic accept;
    logic drop;

    assign pop    = valid_reg & head_ready;
    // A full FIFO still takes a beat when the head leaves in the same cycle.
    assign accept = push & ((level_reg != FULL_LEVEL) | pop);
    assign drop   = push & ~accept;

    assign level_after_pop = level_reg - LEVEL_W'(pop);
    assign level_next      = level_after_pop + LEVEL_W'(accept);
    assign rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);

    // The head is kept in its own register so head_data is a flop output.
    // After this cycle's pop, the new head is either the beat being written
    // now (nothing else left) or the next stored entry.
    always_comb begin
        head_next = head_reg;
        if (level_next != '0) begin
            if (level_after_pop == '0) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            level_reg    <= '0;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            head_reg     <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(accept);
            level_reg  <= level_next;
            valid_reg  <= (level_next != '0);
            head_reg   <= head_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign head_valid = valid_reg;
    assign head_data  = head_reg;
    assign level      = level_reg;
    assign overflow   = overflow_reg;

endmodule

// File: rtl/cordic_out_stage.sv
// ---------------------------------------------------------------------------
// cordic_out_stage
// Output stage for the CORDIC core: scales x and y by the gain-compensation
// constant (two pipeline stages: multiply, then round-half-up) and buffers the
// results in a FWFT FIFO with ready/valid on the consumer side.
//   i_clk, i_rst - clock, synchronous active-high reset
//   i_valid      - result beat from the core (no backpressure)
//   i_data       - core result {x, y, z}
//   o_valid      - FIFO head valid
//   o_ready      - consumer accepts the head
//   o_data       - compensated result at the FIFO head
//   o_level      - FIFO occupancy
//   o_overflow   - sticky; a beat was dropped on a full FIFO
// ---------------------------------------------------------------------------
module cordic_out_stage
    import cordic_out_stage_pkg::*;
#(
    parameter int unsigned GAIN_Q15   = CORDIC_INV_GAIN_Q15,
    parameter bit          GAIN_EN    = 1'b1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    input  cordic_data                    i_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output cordic_data                    o_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_overflow
);

    // ---------------- S1: scale ----------------
    logic signed [31:0] x_prod_next, y_prod_next;

    generate
        if (GAIN_EN) begin : g_gain
            localparam logic signed [31:0] GAIN_S = 32'(GAIN_Q15);
            assign x_prod_next = 32'(i_data.x) * GAIN_S;
            assign y_prod_next = 32'(i_data.y) * GAIN_S;
        end else begin : g_bypass
            // Scaling by exactly 2^15 makes the S2 rounding an identity,
            // so the bypass path shares the same datapath and latency.
            assign x_prod_next = 32'(i_data.x) <<< 15;
            assign y_prod_next = 32'(i_data.y) <<< 15;
        end
    endgenerate

    logic                       s1_valid_reg;
    logic signed [31:0]         s1_x_prod_reg, s1_y_prod_reg;
    logic signed [CORDIC_W-1:0] s1_z_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        s1_x_prod_reg <= x_prod_next;
        s1_y_prod_reg <= y_prod_next;
        s1_z_reg      <= i_data.z;
    end

    // ---------------- S2: round half up ----------------
    // (p + 2^14) >>> 15 truncated to 16 bits is bits [30:15] of the sum.
    // |gain| < 1 keeps the result inside 16 bits, so no saturation.
    logic signed [31:0] x_sum, y_sum;
    logic               unused_round_bits;

    assign x_sum = s1_x_prod_reg + 32'sd16384;
    assign y_sum = s1_y_prod_reg + 32'sd16384;
    assign unused_round_bits = ^{x_sum[31], x_sum[14:0], y_sum[31], y_sum[14:0]};

    logic       s2_valid_reg;
    cordic_data s2_data_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
        end
    end

    always_ff @(posedge i_clk) begin
        s2_data_reg.x <= x_sum[30:15];
        s2_data_reg.y <= y_sum[30:15];
        s2_data_reg.z <= s1_z_reg;
    end

    // ---------------- output buffer ----------------
    cordic_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (i_clk),
        .srst       (i_rst),
        .push       (s2_valid_reg),
        .push_data  (s2_data_reg),
        .head_valid (o_valid),
        .head_ready (o_ready),
        .head_data  (o_data),
        .level      (o_level),
        .overflow   (o_overflow)
    );

endmodule

// File: tb/tb_cordic_out_stage.sv
// ---------------------------------------------------------------------------
// tb_cordic_out_stage
// Drives a gain-compensated and a bypass instance with identical stimulus.
// A transaction-level model (delay line + bounded queue) predicts every
// output each cycle; directed vectors and sequences cover the corner cases.
// ---------------------------------------------------------------------------
module tb_cordic_out_stage;
    import cordic_out_stage_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic       out_ready;
    cordic_data in_data;

    logic       g_valid, b_valid;
    cordic_data g_data, b_data;
    logic [2:0] g_level, b_level;
    logic       g_ovf, b_ovf;

    int total = 0;
    int bad   = 0;

    cordic_out_stage #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (in_valid),
        .i_data     (in_data),
        .o_valid    (g_valid),
        .o_ready    (out_ready),
        .o_data     (g_data),
        .o_level    (g_level),
        .o_overflow (g_ovf)
    );

    cordic_out_stage #(
        .GAIN_EN    (1'b0),
        .FIFO_DEPTH (DEPTH)
    ) dut_bypass (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (in_valid),
        .i_data     (in_data),
        .o_valid    (b_valid),
        .o_ready    (out_ready),
        .o_data     (b_data),
        .o_level    (b_level),
        .o_overflow (b_ovf)
    );

    // ---------------- reference model ----------------
    cordic_data mq[$];
    logic       p0_v = 1'b0, p1_v = 1'b0;
    cordic_data p0_d = '0, p1_d = '0;
    logic       movf = 1'b0;

    // x * 0.607253... rounded half up
    function automatic int scale(input int v);
        real r;
        r = (v * 19898.0) / 32768.0;
        return int'($floor(r + 0.5));
    endfunction

    task automatic model_step();
        bit pop;
        if (rst) begin
            mq.delete();
            p0_v = 1'b0;
            p1_v = 1'b0;
            movf = 1'b0;
        end else begin
            pop = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (p1_v) begin
                if (mq.size() < DEPTH) mq.push_back(p1_d);
                else movf = 1'b1;
            end
            p1_v = p0_v;
            p1_d = p0_d;
            p0_v = in_valid;
            p0_d = in_data;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("valid",     g_valid, mq.size() > 0);
        chk("level",     g_level, mq.size());
        chk("ovf",       g_ovf,   movf);
        chk("byp_valid", b_valid, mq.size() > 0);
        chk("byp_level", b_level, mq.size());
        chk("byp_ovf",   b_ovf,   movf);
        if (mq.size() > 0) begin
            chk("data_x",     g_data.x, scale(mq[0].x));
            chk("data_y",     g_data.y, scale(mq[0].y));
            chk("data_z",     g_data.z, mq[0].z);
            chk("byp_data_x", b_data.x, mq[0].x);
            chk("byp_data_y", b_data.y, mq[0].y);
            chk("byp_data_z", b_data.z, mq[0].z);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input int x, input int y, input int z);
        in_valid  = 1'b1;
        in_data.x = 16'(x);
        in_data.y = 16'(y);
        in_data.z = 16'(z);
    endtask

    task automatic send_rand();
        send(int'($urandom), int'($urandom), int'($urandom));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = cordic_data'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int x, y, z;
        int ex, ey;     // gain-compensated
        int bx, by;     // bypass
    } vec_t;

    vec_t vecs[5];

    cordic_data held;
    int         vcount, first_v, last_v;

    initial begin
        vecs[0] = '{x: 16384,  y: -16384, z: 1000, ex: 9949,  ey: -9949,  bx: 16384, by: -16384};
        vecs[1] = '{x: 32767,  y: -32768, z: 5,    ex: 19897, ey: -19898, bx: 32767, by: -32768};
        vecs[2] = '{x: 0,      y: 0,      z: -1,   ex: 0,     ey: 0,      bx: 0,     by: 0};
        vecs[3] = '{x: 1,      y: -1,     z: 7,    ex: 1,     ey: -1,     bx: 1,     by: -1};
        vecs[4] = '{x: 100,    y: -100,   z: 0,    ex: 61,    ey: -61,    bx: 100,   by: -100};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        tick();
        tick();
        chk("rst_data_x",     g_data.x, 0);
        chk("rst_data_y",     g_data.y, 0);
        chk("rst_data_z",     g_data.z, 0);
        chk("rst_byp_data_x", b_data.x, 0);
        rst = 1'b0;
        tick();

        // Single beats: latency N+3 and exact arithmetic
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].z);
            tick();
            idle();
            tick();
            chk("lat_early_valid", g_valid, 0);
            tick();
            chk("vec_valid", g_valid, 1);
            chk("vec_x",     g_data.x, vecs[i].ex);
            chk("vec_y",     g_data.y, vecs[i].ey);
            chk("vec_z",     g_data.z, vecs[i].z);
            chk("vec_byp_x", b_data.x, vecs[i].bx);
            chk("vec_byp_y", b_data.y, vecs[i].by);
            tick();
            tick();
        end

        // Backpressure: fill, then drop a fifth beat
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send_rand();
            tick();
        end
        idle();
        repeat (3) tick();
        chk("bp_level", g_level, DEPTH);
        chk("bp_ovf",   g_ovf, 0);
        held = g_data;
        send_rand();
        tick();
        idle();
        tick();
        tick();
        chk("drop_ovf",    g_ovf, 1);
        chk("drop_level",  g_level, DEPTH);
        chk("drop_head_x", g_data.x, held.x);
        chk("drop_head_z", g_data.z, held.z);
        tick();
        chk("ovf_sticky",  g_ovf, 1);

        // Full FIFO with a pop on the push cycle: nothing lost
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            send_rand();
            tick();
        end
        idle();
        repeat (3) tick();
        send_rand();
        tick();
        idle();
        tick();
        out_ready = 1'b1;
        tick();
        chk("fullpop_level", g_level, DEPTH);
        chk("fullpop_ovf",   g_ovf, 0);
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        chk("fullpop_drained", g_level, 0);

        // Streaming 20 beats back-to-back through the wrapping pointers
        do_reset();
        out_ready = 1'b1;
        vcount  = 0;
        first_v = -1;
        last_v  = -1;
        for (int c = 0; c < 26; c++) begin
            if (c < 20) send_rand();
            else idle();
            tick();
            if (g_valid) begin
                vcount++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        chk("stream_count",  vcount, 20);
        chk("stream_b2b",    last_v - first_v + 1, 20);
        chk("stream_ovf",    g_ovf, 0);

        // Reset with 3 queued and 2 in flight
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_rand();
            tick();
        end
        idle();
        repeat (3) tick();
        send_rand();
        tick();
        send_rand();
        tick();
        chk("mid_level_before", g_level, 3);
        rst = 1'b1;
        send_rand();
        tick();
        chk("mid_rst_valid", g_valid, 0);
        chk("mid_rst_level", g_level, 0);
        chk("mid_rst_ovf",   g_ovf, 0);
        chk("mid_rst_data",  g_data.z, 0);
        rst = 1'b0;
        send(16384, -16384, 1234);
        tick();
        idle();
        tick();
        chk("post_rst_early", g_valid, 0);
        tick();
        chk("post_rst_valid", g_valid, 1);
        chk("post_rst_x",     g_data.x, 9949);
        chk("post_rst_z",     g_data.z, 1234);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0) send_rand();
            else idle();
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        idle();
        out_ready = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cordic_out_stage.md
# cordic_out_stage

Downstream output stage for the CORDIC core. It takes the core's raw result beat (valid + data, no backpressure), multiplies x and y by the CORDIC gain-compensation constant, and rounds them. Results are buffered in a small FIFO so the consumer can apply ready/valid backpressure. The core cannot be stalled, so any result that arrives while the buffer is full is dropped, and a sticky overflow flag records the loss.

## Interface
- GAIN_Q15, default 19898: 1/K in unsigned Q0.15 (0.607253 for 12 micro-rotations).
- GAIN_EN, default 1: 1 applies gain compensation; 0 passes x and y through unchanged, with the same latency.
- FIFO_DEPTH, default 4: output buffer entries. Power of two, at least 2.

- i_clk  input  1  clock; sole clock domain.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  result beat from the core; one beat per asserted cycle.
- i_data  input  cordic_data  core result {x, y, z}, each signed CORDIC_W = 16.
- o_valid  output  1  FIFO head is valid.
- o_ready  input  1  consumer accepts the head this cycle.
- o_data  output  cordic_data  compensated result at the FIFO head.
- o_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_overflow  output  1  sticky; set when a beat is dropped.

## Operation
- **Pipeline stage S1:** registers x·GAIN_Q15 and y·GAIN_Q15 as signed 32-bit products, plus z and the valid bit.
- **Pipeline stage S2:** computes (product + 2^14) >>> 15, an arithmetic shift giving round-half-up, and truncates to 16 bits.
  - |gain| < 1, so the result can never overflow and no saturation is needed.
  - z passes through both stages unmodified.
- **GAIN_EN = 0:** S1 and S2 still register the data, but x and y bypass the multiply.
- **FIFO write:** S2 valid pushes into the FIFO.
- **FIFO read:** the FIFO is first-word-fall-through. A pop occurs when o_valid && o_ready.
- **Full FIFO:**
  - A push is accepted if a pop happens in the same cycle.
  - Otherwise the beat is discarded and o_overflow is set.
  - o_overflow stays set until reset.
- **Push and pop together:** allowed at any occupancy. o_level is unchanged.
- **Pointers:** read and write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by o_level.
- **Reset:** clears the S1/S2 valid bits, FIFO pointers, o_level and o_overflow. Beats in flight are lost.
- **Reset values of outputs:** o_valid 0, o_level 0, o_overflow 0, o_data 0.
- **Empty FIFO:** o_data is don't-care while o_valid is 0. The bench must not check it.

## Timing
- i_valid at cycle N: S1 valid at N+1, S2 valid at N+2, o_valid at N+3 (FIFO empty, no pending head).
- Sustained throughput is one beat per cycle when o_ready is held high.
- o_valid, o_data and o_level are register outputs. There is no combinational path from o_ready to o_valid.
- o_ready deasserted while o_valid is high: o_data must be held stable.
- o_level updates the cycle after each push or pop.
- o_overflow rises the cycle after the dropped push.
- i_rst asserted at cycle M: all outputs hold reset values from M+1. Input beats are ignored while i_rst is high.

## Structure
- Add to the shared package: CORDIC_W, the cordic_data struct, and a CORDIC_INV_GAIN_Q15 constant. The GAIN_Q15 default comes from that constant.
- One sub-module, cordic_out_fifo: a parameterised FWFT FIFO with push/full/drop logic and level output.
- The scaling pipeline stays in cordic_out_stage.

## Test plan
- **Single beat:** x=16384, y=-16384, z=1000 with o_ready=1 -> at N+3, o_valid=1 and o_data = {9949, -9949, 1000}.
- **Extremes:** x=32767, y=-32768 -> x=19897, y=-19898. With GAIN_EN=0 -> x=32767, y=-32768 unchanged.
- **Backpressure:** o_ready=0, 4 beats into FIFO_DEPTH=4 -> o_level=4, o_overflow=0, head stable. A 5th beat is dropped: o_overflow=1, o_level stays 4.
- **Full with pop:** FIFO full, o_ready=1 on the same cycle as an S2 push -> no drop, o_level stays 4, and output order is preserved.
- **Streaming with wrap:** 20 consecutive beats, o_ready=1 -> 20 outputs in order, back-to-back, o_overflow=0.
- **Reset mid-stream:** i_rst pulsed with 3 entries queued and 2 beats in flight -> o_valid=0, o_level=0, o_overflow=0 next cycle. A new beat after reset appears 3 cycles later.
